// File: rtl/lpm_mac_pipe.sv
// Pipelined multiply-accumulate: stage 1 registers the full-width product,
// stage 2 accumulates it and emits one dot-product result per in_last vector.
module lpm_mac_pipe #(
  parameter int    LPM_WIDTHA         = 9,
  parameter int    LPM_WIDTHB         = 8,
  parameter int    LPM_WIDTHP         = 24,
  parameter string LPM_REPRESENTATION = "UNSIGNED",
  parameter int    LPM_SATURATE       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [LPM_WIDTHA-1:0] dataa,
  input  logic [LPM_WIDTHB-1:0] datab,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LPM_WIDTHP-1:0] result,
  output logic                  overflow
);
  localparam int WM  = LPM_WIDTHA + LPM_WIDTHB;
  localparam int WP  = LPM_WIDTHP;
  localparam bit SGN = (LPM_REPRESENTATION == "SIGNED");
  localparam bit SAT = (LPM_SATURATE != 0);

  logic          xfer;
  logic          s1_vld, s1_last;
  logic [WM-1:0] s1_prod, prod, a_x, b_x;
  logic [WP-1:0] acc, prod_ext, sum, sat_val, acc_nxt;
  logic          acc_ovf, ovf, carry;

  // A pending, unaccepted result freezes the whole pipeline.
  assign in_ready = !(out_valid && !out_ready);
  assign xfer     = in_valid && in_ready;

  generate
    if (SGN) begin : g_sgn
      assign a_x      = WM'($signed(dataa));
      assign b_x      = WM'($signed(datab));
      assign prod_ext = WP'($signed(s1_prod));
    end else begin : g_uns
      assign a_x      = WM'(dataa);
      assign b_x      = WM'(datab);
      assign prod_ext = WP'(s1_prod);
    end
  endgenerate

  // Truncating to WM bits keeps the exact product in both modes.
  assign prod = a_x * b_x;
  assign {carry, sum} = {1'b0, acc} + {1'b0, prod_ext};

  always_comb begin
    ovf     = carry;
    sat_val = '1;
    if (SGN) begin
      ovf     = (acc[WP-1] == prod_ext[WP-1]) && (sum[WP-1] != acc[WP-1]);
      // Same-sign overflow: the accumulator sign gives the clamp direction.
      sat_val = acc[WP-1] ? {1'b1, {(WP-1){1'b0}}} : {1'b0, {(WP-1){1'b1}}};
    end
    acc_nxt = (ovf && SAT) ? sat_val : sum;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld    <= 1'b0;
      s1_last   <= 1'b0;
      s1_prod   <= '0;
      acc       <= '0;
      acc_ovf   <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (in_ready) begin
        s1_vld <= xfer;
        if (xfer) begin
          s1_prod <= prod;
          s1_last <= in_last;
        end
        if (s1_vld) begin
          if (s1_last) begin
            result    <= acc_nxt;
            overflow  <= acc_ovf | ovf;
            out_valid <= 1'b1;
            acc       <= '0;
            acc_ovf   <= 1'b0;
          end else begin
            acc     <= acc_nxt;
            acc_ovf <= acc_ovf | ovf;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_lpm_mac_pipe.sv
// Four configurations share one stimulus stream; a queue-based arithmetic
// model scores every result, directed tables pin the corner cases.
module tb_lpm_mac_pipe;
  logic        clk = 1'b0, reset, in_valid, in_last, out_ready;
  logic [8:0]  a;
  logic [7:0]  b;
  logic [3:0]  in_ready, out_valid, overflow;
  logic [23:0] res0;
  logic [15:0] res1, res2, res3;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  lpm_mac_pipe u0 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_last(in_last), .dataa(a), .datab(b), .out_valid(out_valid[0]), .out_ready(out_ready),
    .result(res0), .overflow(overflow[0]));
  lpm_mac_pipe #(.LPM_WIDTHA(8), .LPM_WIDTHB(8), .LPM_WIDTHP(16), .LPM_REPRESENTATION("SIGNED"),
    .LPM_SATURATE(0)) u1 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_last(in_last), .dataa(a[7:0]), .datab(b), .out_valid(out_valid[1]), .out_ready(out_ready),
    .result(res1), .overflow(overflow[1]));
  lpm_mac_pipe #(.LPM_WIDTHA(8), .LPM_WIDTHB(8), .LPM_WIDTHP(16), .LPM_REPRESENTATION("SIGNED"),
    .LPM_SATURATE(1)) u2 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[2]),
    .in_last(in_last), .dataa(a[7:0]), .datab(b), .out_valid(out_valid[2]), .out_ready(out_ready),
    .result(res2), .overflow(overflow[2]));
  lpm_mac_pipe #(.LPM_WIDTHA(8), .LPM_WIDTHB(8), .LPM_WIDTHP(16), .LPM_REPRESENTATION("UNSIGNED"),
    .LPM_SATURATE(1)) u3 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[3]),
    .in_last(in_last), .dataa(a[7:0]), .datab(b), .out_valid(out_valid[3]), .out_ready(out_ready),
    .result(res3), .overflow(overflow[3]));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Sequential dot product with plain integer range checks.
  function automatic void model(input longint p[$], input bit sgn, input bit sat, input int pw,
                                output longint r, output bit ov);
    longint m = longint'(1) << pw;
    longint lo = sgn ? -(m / 2) : 0;
    longint hi = sgn ? (m / 2) - 1 : m - 1;
    longint acc = 0, s;
    ov = 1'b0;
    foreach (p[i]) begin
      s = acc + p[i];
      if (s > hi || s < lo) begin
        ov = 1'b1;
        if (sat) s = (s > hi) ? hi : lo;
        else s = ((((s - lo) % m) + m) % m) + lo;
      end
      acc = s;
    end
    r = acc & (m - 1);
  endfunction

  typedef struct packed { logic [3:0][23:0] r; logic [3:0] o; } exp_t;
  exp_t   expq[$];
  longint pu[$], ps[$], p8[$];

  always @(negedge clk) begin
    exp_t   e;
    longint r;
    bit     o;
    logic [3:0][23:0] got;
    got = {8'h0, res3, 8'h0, res2, 8'h0, res1, res0};
    if (reset) begin
      expq.delete(); pu.delete(); ps.delete(); p8.delete();
    end else begin
      chk("sb_vld_agree", out_valid, {4{out_valid[0]}});
      if (out_valid[0] && out_ready) begin
        if (expq.size() == 0) chk("sb_unexpected_result", 1, 0);
        else begin
          e = expq.pop_front();
          for (int k = 0; k < 4; k++) begin
            chk($sformatf("sb_result%0d", k), got[k], e.r[k]);
            chk($sformatf("sb_ovf%0d", k), overflow[k], e.o[k]);
          end
        end
      end
      if (in_valid && in_ready[0]) begin
        pu.push_back(longint'(a) * longint'(b));
        ps.push_back(longint'($signed(a[7:0])) * longint'($signed(b)));
        p8.push_back(longint'(a[7:0]) * longint'(b));
        if (in_last) begin
          model(pu, 0, 0, 24, r, o); e.r[0] = 24'(r); e.o[0] = o;
          model(ps, 1, 0, 16, r, o); e.r[1] = 24'(r); e.o[1] = o;
          model(ps, 1, 1, 16, r, o); e.r[2] = 24'(r); e.o[2] = o;
          model(p8, 0, 1, 16, r, o); e.r[3] = 24'(r); e.o[3] = o;
          expq.push_back(e);
          pu.delete(); ps.delete(); p8.delete();
        end
      end
    end
  end

  typedef struct {
    logic [8:0] a; logic [7:0] b; bit last;
    logic [23:0] r0; logic [15:0] r1, r2, r3; logic [3:0] ov;
  } row_t;
  row_t tbl[11];

  function automatic row_t mk(logic [8:0] ra, logic [7:0] rb, bit l, logic [23:0] r0,
                              logic [15:0] r1, logic [15:0] r2, logic [15:0] r3, logic [3:0] ov);
    row_t t;
    t.a = ra; t.b = rb; t.last = l; t.r0 = r0; t.r1 = r1; t.r2 = r2; t.r3 = r3; t.ov = ov;
    return t;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [8:0] ba, input logic [7:0] bb, input bit l);
    a = ba; b = bb; in_last = l; in_valid = 1'b1;
  endtask

  initial begin
    tbl[0]  = mk(9'd3, 8'd4, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(9'd5, 8'd6, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(9'd7, 8'd8, 1, 24'd98, 16'd98, 16'd98, 16'd98, 4'b0000);
    tbl[3]  = mk(9'h080, 8'h80, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(9'h080, 8'h80, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(9'h080, 8'h80, 1, 24'hC000, 16'hC000, 16'h7FFF, 16'hC000, 4'b0110);
    tbl[6]  = mk(9'h0FF, 8'hFF, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(9'h0FF, 8'hFF, 1, 24'h1FC02, 16'd2, 16'd2, 16'hFFFF, 4'b1000);
    tbl[8]  = mk(9'h080, 8'h7F, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(9'h080, 8'h7F, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(9'h080, 8'h7F, 1, 24'hBE80, 16'h4180, 16'h8000, 16'hBE80, 4'b0110);

    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 4'h0);
    chk("rst_in_ready", in_ready, 4'hF);
    chk("rst_result0", res0, 24'h0);
    chk("rst_overflow", overflow, 4'h0);
    step(); reset = 1'b0; out_ready = 1'b1;

    foreach (tbl[i]) begin
      beat(tbl[i].a, tbl[i].b, tbl[i].last);
      @(negedge clk); chk($sformatf("tbl%0d_in_ready", i), in_ready[0], 1'b1);
      step();
      if (tbl[i].last) begin
        in_valid = 1'b0;
        @(negedge clk); chk($sformatf("tbl%0d_lat_early", i), out_valid[0], 1'b0);
        step();
        @(negedge clk);
        chk($sformatf("tbl%0d_out_valid", i), out_valid, 4'hF);
        chk($sformatf("tbl%0d_res0", i), res0, tbl[i].r0);
        chk($sformatf("tbl%0d_res1", i), res1, tbl[i].r1);
        chk($sformatf("tbl%0d_res2", i), res2, tbl[i].r2);
        chk($sformatf("tbl%0d_res3", i), res3, tbl[i].r3);
        chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].ov);
        step();
      end
    end

    // Back-to-back single-beat vectors.
    beat(9'd2, 8'd3, 1); step();
    beat(9'd4, 8'd5, 1); step();
    in_valid = 1'b0;
    @(negedge clk); chk("b2b_first_vld", out_valid[0], 1'b1); chk("b2b_first", res0, 24'd6);
    step();
    @(negedge clk); chk("b2b_second_vld", out_valid[0], 1'b1); chk("b2b_second", res0, 24'd20);
    step();

    // Backpressure: offered beat must wait until the pending result drains.
    out_ready = 1'b0;
    beat(9'd2, 8'd2, 1); step();
    in_valid = 1'b0; step();
    beat(9'd3, 8'd3, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready_low", in_ready[0], 1'b0);
      chk("bp_result_hold", res0, 24'd4);
      chk("bp_vld_hold", out_valid[0], 1'b1);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk); chk("bp_in_ready_resume", in_ready[0], 1'b1);
    step();
    in_valid = 1'b0;
    @(negedge clk); chk("bp_drained", out_valid[0], 1'b0);
    step();
    @(negedge clk); chk("bp_next_vld", out_valid[0], 1'b1); chk("bp_next", res0, 24'd9);
    step();

    // Reset in the middle of a vector discards the partial sum.
    beat(9'd5, 8'd5, 0); step();
    beat(9'd6, 8'd6, 0); step();
    in_valid = 1'b0; reset = 1'b1; step();
    reset = 1'b0;
    beat(9'd1, 8'd1, 1); step();
    in_valid = 1'b0; step();
    @(negedge clk);
    chk("mrst_vld", out_valid, 4'hF);
    chk("mrst_res0", res0, 24'd1);
    chk("mrst_res1", res1, 16'd1);
    chk("mrst_ovf", overflow, 4'h0);
    step();

    // Random traffic, biased toward large operands so overflow paths fire.
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_last   = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 1) != 0) ? 9'($urandom) : {1'b0, 1'b1, 7'($urandom)};
      b = ($urandom_range(0, 1) != 0) ? 8'($urandom) : {1'b1, 7'($urandom)};
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) step();
    chk("sb_drained", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
